// File: rtl/display_scan.sv
// display_scan: bit-plane scan controller driving a HUB-style LED panel from a double-banded frame memory
module display_scan #(
  parameter int segments    = 1,
  parameter int rows        = 8,
  parameter int columns     = 32,
  parameter int width       = 24,
  parameter int base_cycles = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [$clog2(rows)-1:0]       rrow,
  output logic [$clog2(columns)-1:0]    rcol,
  input  logic [width*segments-1:0]     rdata,
  output logic                          flip,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic [segments-1:0]           r,
  output logic [segments-1:0]           g,
  output logic [segments-1:0]           b,
  output logic                          pclk,
  output logic                          lat,
  output logic                          oe_n,
  output logic [$clog2(rows)-1:0]       addr
);
  localparam int depth = width / 3;
  localparam int rw = $clog2(rows);
  localparam int cw = $clog2(columns);
  localparam int kw = $clog2(2 * columns + 1);
  localparam int pw = depth > 1 ? $clog2(depth) : 1;
  localparam int dw = $clog2((base_cycles << (depth - 1)) + 1);

  typedef enum logic [1:0] {SHIFT, LATCH, DISPLAY} state_t;

  state_t        state, state_nx;
  logic [rw-1:0] n;
  logic [pw-1:0] p;
  logic [kw-1:0] k;
  logic [dw-1:0] d;
  logic          shift_done, disp_done, frame_end, en;

  assign rrow = n;

  // next state, phase-end decode and panel strobes; rcol walks two cycles per column after the priming cycle
  always_comb begin
    shift_done = state == SHIFT && k == kw'(2 * columns);
    disp_done  = state == DISPLAY && d == dw'((base_cycles << p) - 1);
    frame_end  = disp_done && n == rw'(rows - 1) && p == pw'(depth - 1);
    state_nx   = shift_done ? LATCH : state == LATCH ? DISPLAY : disp_done ? SHIFT : state;
    en         = state == SHIFT && k != '0;
    pclk       = en && !k[0];
    lat        = state == LATCH;
    oe_n       = state != DISPLAY;
    rcol       = state == SHIFT && k < kw'(2 * columns) ? cw'(k >> 1) : '0;
  end

  // colour bits: rdata already belongs to the current column on both the setup and the pclk-high cycle
  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    for (int s = 0; s < segments; s++) begin
      r[s] = en && rdata[s * width + 2 * depth + int'(p)];
      g[s] = en && rdata[s * width + depth + int'(p)];
      b[s] = en && rdata[s * width + int'(p)];
    end
  end

  // state register, plane/row iteration, row address latch and bank swap at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SHIFT;
      n        <= '0;
      p        <= '0;
      k        <= '0;
      d        <= '0;
      addr     <= '0;
      flip     <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      state    <= state_nx;
      k        <= state == SHIFT && !shift_done ? k + 1'b1 : '0;
      d        <= state == DISPLAY && !disp_done ? d + 1'b1 : '0;
      addr     <= shift_done ? n : addr;
      p        <= disp_done ? (p == pw'(depth - 1) ? '0 : p + 1'b1) : p;
      n        <= disp_done && p == pw'(depth - 1) ? (n == rw'(rows - 1) ? '0 : n + 1'b1) : n;
      flip     <= flip ^ (frame_end && swap_req);
      swap_ack <= frame_end && swap_req;
    end
  end
endmodule
